seq_tracker: RTL and testbench
==============================

# seq_tracker

Sequence tracker for the matrix-display sequence stream. It samples a 4-bit scrambled sequence value on each clock-enable strobe and decodes it back to its 4-bit position index. It then infers the stepping direction, locks after a run of consistent steps, and flags and counts out-of-sequence values. It sits at the receiving end of the display sequence generator's output and checks that stream.

## Interface

- LOCK_CNT, 3: consecutive same-direction single steps needed to lock (1..15).
- LOSS_CNT, 2: consecutive bad steps while locked that force loss of lock (1..15).
- ERR_W, 8: width of the error counter.

- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ce  in  1  sample strobe; seq_in is sampled only on edges where ce=1.
- seq_in  in  4  scrambled sequence value.
- clr_err  in  1  synchronous clear of err_cnt.
- pos  out  4  decoded position index of the last sample.
- pos_valid  out  1  equals locked.
- locked  out  1  tracker locked.
- dir  out  1  locked direction; 1=up (index +1), 0=down (index -1).
- step_err  out  1  one-cycle pulse on a bad step while locked.
- err_cnt  out  ERR_W  saturating count of bad steps.

## Operation

- Fixed decode table, value->index: 0->9, 1->1, 2->D, 3->B, 4->8, 5->7, 6->6, 7->0, 8->2, 9->3, A->F, B->E, C->4, D->C, E->A, F->5.
- The table is a bijection, so every value decodes and none is illegal by itself.
- On each ce: idx = decode(seq_in); delta = idx - prev_idx mod 16; prev_idx <= idx; pos <= idx.
- Step classes: delta=1 is up; delta=F is down; delta=0 is hold; any other delta is a jump.
- Wrap-around is inherent: F->0 is up and 0->F is down.
- IDLE (reset state): first ce stores prev_idx and pos, sets good_cnt=0, and moves to HUNT.
- HUNT, up or down step:
  - If good_cnt=0 or the step matches cand_dir: good_cnt+1 and cand_dir=step.
  - If the step opposes cand_dir: good_cnt=1 and cand_dir=step.
  - When good_cnt reaches LOCK_CNT: go to LOCKED with dir=cand_dir and bad_cnt=0.
- HUNT, hold: no change. Jump: good_cnt=0.
- HUNT never raises step_err or changes err_cnt.
- LOCKED, step in dir: bad_cnt=0.
- LOCKED, step opposite dir: legal reversal; dir flips, bad_cnt=0, no error.
- LOCKED, hold: legal, no change.
- LOCKED, jump: step_err=1 and err_cnt+1 (saturates at all-ones); bad_cnt+1.
  - When bad_cnt reaches LOSS_CNT: go to HUNT with good_cnt=0; dir holds its last value.
- ce=0: all state holds, step_err=0, seq_in is ignored.
- clr_err=1 sets err_cnt=0 and takes priority over a same-cycle increment. step_err still pulses in that case.

## Timing

- Reset values: pos=0, pos_valid=0, locked=0, dir=1, step_err=0, err_cnt=0; state=IDLE, prev_idx=0, good_cnt=0, bad_cnt=0.
- Reset mid-operation returns to IDLE immediately. The next ce is treated as a first sample.
- All outputs are registered and update on the edge that samples ce=1, so they are visible in the following cycle.
- locked rises after the edge sampling the (LOCK_CNT+1)-th sample of a clean run. With default LOCK_CNT, that is the 4th sample.
- locked falls after the edge sampling the LOSS_CNT-th consecutive jump. step_err pulses on that same edge.
- step_err is high for exactly one clk cycle per bad step, even if ce stays high on back-to-back cycles.

## Test plan

- Lock up: after reset, ce each cycle with seq_in=7,1,8,9 -> locked=1 and dir=1 after the 4th sample; pos=3; err_cnt=0.
- Wrap: locked up, feed A,7,1 (idx F,0,1) -> no step_err; pos=1.
- Lock down: after reset, feed 7,A,B,2 (idx 0,F,E,D) -> locked=1, dir=0, pos=D. Then feed B (idx E) -> dir=1, no error.
- Errors and loss: locked up at pos=3, feed 5 (idx 7) -> step_err pulse, err_cnt=1, still locked. Then feed 0 (idx 9) -> err_cnt=2, locked=0. Then feed 4,E,3 (idx 8,A,B) -> HUNT counts only the A->B step, so locked stays 0.
- Hold and gating: locked, repeat the same seq_in with ce=1 -> no error. With ce=0, drive random seq_in -> no output changes.
- Reset/clear: assert clr_err together with a jump -> step_err=1, err_cnt=0. Assert rst mid-lock -> all outputs return to their reset values, and the next ce moves to HUNT only.

Source files
------------

// File: rtl/seq_tracker.sv
// rtl/seq_tracker.sv - decodes the scrambled display sequence and tracks lock, direction and step errors
module seq_tracker #(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [3:0]       seq_in,
    input  logic             clr_err,
    output logic [3:0]       pos,
    output logic             pos_valid,
    output logic             locked,
    output logic             dir,
    output logic             step_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HUNT   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

    function automatic logic [3:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 4'h9;
            4'h1: decode = 4'h1;
            4'h2: decode = 4'hD;
            4'h3: decode = 4'hB;
            4'h4: decode = 4'h8;
            4'h5: decode = 4'h7;
            4'h6: decode = 4'h6;
            4'h7: decode = 4'h0;
            4'h8: decode = 4'h2;
            4'h9: decode = 4'h3;
            4'hA: decode = 4'hF;
            4'hB: decode = 4'hE;
            4'hC: decode = 4'h4;
            4'hD: decode = 4'hC;
            4'hE: decode = 4'hA;
            default: decode = 4'h5;
        endcase
    endfunction

    logic [1:0] state;
    logic [3:0] prev_idx;
    logic [3:0] good_cnt;
    logic [3:0] bad_cnt;
    logic       cand_dir;

    logic [3:0] idx;
    logic [3:0] delta;
    logic       is_up;
    logic       is_down;
    logic       is_hold;
    logic       is_step;
    logic [3:0] hunt_good;
    logic [3:0] bad_next;

    always_comb begin
        idx       = decode(seq_in);
        delta     = idx - prev_idx;
        is_up     = (delta == 4'h1);
        is_down   = (delta == 4'hF);
        is_hold   = (delta == 4'h0);
        is_step   = is_up | is_down;
        // An opposing step restarts the run at one rather than zero: it is itself a good step.
        hunt_good = ((good_cnt == 4'd0) || (is_up == cand_dir)) ? good_cnt + 4'd1 : 4'd1;
        bad_next  = bad_cnt + 4'd1;
    end

    assign pos_valid = locked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            prev_idx <= 4'h0;
            good_cnt <= 4'd0;
            bad_cnt  <= 4'd0;
            cand_dir <= 1'b1;
            pos      <= 4'h0;
            locked   <= 1'b0;
            dir      <= 1'b1;
            step_err <= 1'b0;
            err_cnt  <= '0;
        end else begin
            step_err <= 1'b0;
            if (ce) begin
                prev_idx <= idx;
                pos      <= idx;
                case (state)
                    ST_IDLE: begin
                        good_cnt <= 4'd0;
                        state    <= ST_HUNT;
                    end
                    ST_HUNT: begin
                        if (is_step) begin
                            good_cnt <= hunt_good;
                            cand_dir <= is_up;
                            if (hunt_good == LOCK_N) begin
                                state   <= ST_LOCKED;
                                locked  <= 1'b1;
                                dir     <= is_up;
                                bad_cnt <= 4'd0;
                            end
                        end else if (!is_hold) begin
                            good_cnt <= 4'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (is_step) begin
                            dir     <= is_up;
                            bad_cnt <= 4'd0;
                        end else if (!is_hold) begin
                            step_err <= 1'b1;
                            bad_cnt  <= bad_next;
                            if (err_cnt != {ERR_W{1'b1}})
                                err_cnt <= err_cnt + ERR_W'(1);
                            if (bad_next == LOSS_N) begin
                                state    <= ST_HUNT;
                                locked   <= 1'b0;
                                good_cnt <= 4'd0;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
            if (clr_err)
                err_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_seq_tracker.sv
// tb/tb_seq_tracker.sv - randomized and directed checks of seq_tracker against a behavioural model
module tb_seq_tracker;

    localparam int LOCK_CNT = 3;
    localparam int LOSS_CNT = 2;
    localparam int ERR_W    = 4;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ce = 1'b0;
    logic [3:0]       seq_in = 4'h0;
    logic             clr_err = 1'b0;
    logic [3:0]       pos;
    logic             pos_valid;
    logic             locked;
    logic             dir;
    logic             step_err;
    logic [ERR_W-1:0] err_cnt;

    seq_tracker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .ce(ce), .seq_in(seq_in), .clr_err(clr_err),
        .pos(pos), .pos_valid(pos_valid), .locked(locked), .dir(dir),
        .step_err(step_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: position index per scrambled value and its inverse for stimulus generation.
    int dec [16] = '{9, 1, 13, 11, 8, 7, 6, 0, 2, 3, 15, 14, 4, 12, 10, 5};
    int enc [16];

    bit m_started, m_locked, m_dir, m_serr;
    int m_prev, m_pos, m_good, m_cand, m_bad, m_err;

    function automatic void model_reset();
        m_started = 0; m_locked = 0; m_dir = 1; m_serr = 0;
        m_prev = 0; m_pos = 0; m_good = 0; m_cand = 1; m_bad = 0; m_err = 0;
    endfunction

    function automatic void model_step(input bit c, input int v, input bit clr);
        int i, d, s;
        m_serr = 0;
        if (c) begin
            i = dec[v];
            d = (i - m_prev + 16) % 16;
            if (!m_started) begin
                m_started = 1;
                m_good = 0;
            end else if (!m_locked) begin
                if (d == 1 || d == 15) begin
                    s = (d == 1);
                    m_good = (m_good == 0 || s == m_cand) ? m_good + 1 : 1;
                    m_cand = s;
                    if (m_good == LOCK_CNT) begin
                        m_locked = 1; m_dir = s[0]; m_bad = 0;
                    end
                end else if (d != 0) begin
                    m_good = 0;
                end
            end else begin
                if (d == 1 || d == 15) begin
                    m_dir = (d == 1); m_bad = 0;
                end else if (d != 0) begin
                    m_serr = 1;
                    if (m_err < ERR_MAX) m_err++;
                    m_bad++;
                    if (m_bad == LOSS_CNT) begin
                        m_locked = 0; m_good = 0;
                    end
                end
            end
            m_prev = i;
            m_pos = i;
        end
        if (clr) m_err = 0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".pos"}, int'(pos), m_pos);
        check({tag, ".locked"}, int'(locked), int'(m_locked));
        check({tag, ".pos_valid"}, int'(pos_valid), int'(m_locked));
        check({tag, ".dir"}, int'(dir), int'(m_dir));
        check({tag, ".step_err"}, int'(step_err), int'(m_serr));
        check({tag, ".err_cnt"}, int'(err_cnt), m_err);
    endtask

    task automatic cycle(input bit c, input int v, input bit clr, input string tag);
        ce = c; seq_in = 4'(v); clr_err = clr;
        @(posedge clk);
        model_step(c, v, clr);
        #1;
        check_all(tag);
    endtask

    task automatic feed(input int v, input string tag);
        cycle(1'b1, v, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #2 rst = 1'b0;
        ce = 1'b0; clr_err = 1'b0;
    endtask

    int cur, walk_dir, r, snap_pos, snap_err;

    initial begin
        for (int k = 0; k < 16; k++) enc[dec[k]] = k;
        model_reset();
        rst = 1'b1;
        #1;
        check_all("reset");
        #12 rst = 1'b0;
        @(negedge clk);

        // Lock up then wrap F->0->1
        foreach (dec[k]) if (k < 0) $display("unreachable");
        feed(4'h7, "up"); feed(4'h1, "up"); feed(4'h8, "up"); feed(4'h9, "up");
        check("lock_up.locked", int'(locked), 1);
        check("lock_up.pos", int'(pos), 3);
        feed(enc[4], "up"); feed(enc[5], "up");
        for (int k = 6; k < 16; k++) feed(enc[k], "walk");
        feed(4'hA, "wrap"); feed(4'h7, "wrap"); feed(4'h1, "wrap");
        check("wrap.pos", int'(pos), 1);
        check("wrap.step_err", int'(step_err), 0);

        // Lock down, then legal reversal
        do_reset("rst_dn");
        feed(4'h7, "dn"); feed(4'hA, "dn"); feed(4'hB, "dn"); feed(4'h2, "dn");
        check("lock_dn.dir", int'(dir), 0);
        check("lock_dn.pos", int'(pos), 13);
        feed(4'hB, "rev");
        check("rev.dir", int'(dir), 1);

        // Errors and loss of lock, then a partial re-hunt
        do_reset("rst_err");
        feed(4'h7, "e"); feed(4'h1, "e"); feed(4'h8, "e"); feed(4'h9, "e");
        feed(4'h5, "jump1");
        check("jump1.step_err", int'(step_err), 1);
        check("jump1.locked", int'(locked), 1);
        feed(4'h0, "jump2");
        check("jump2.err_cnt", int'(err_cnt), 2);
        check("jump2.locked", int'(locked), 0);
        feed(4'h4, "rehunt"); feed(4'hE, "rehunt"); feed(4'h3, "rehunt");
        check("rehunt.locked", int'(locked), 0);

        // Hold while locked, then ce gating with random seq_in
        feed(enc[12], "relock"); feed(enc[13], "relock"); feed(enc[14], "relock");
        for (int k = 0; k < 3; k++) feed(enc[14], "hold");
        snap_pos = int'(pos);
        for (int k = 0; k < 8; k++) cycle(1'b0, $urandom_range(0, 15), 1'b0, "gate");
        check("gate.pos", int'(pos), snap_pos);

        // Clear wins over a same-cycle jump increment
        cycle(1'b1, enc[2], 1'b1, "clr_jump");
        check("clr_jump.step_err", int'(step_err), 1);
        check("clr_jump.err_cnt", int'(err_cnt), 0);

        // Saturate: relock, one jump, one recovering step, repeated
        feed(enc[3], "sat"); feed(enc[4], "sat"); feed(enc[5], "sat");
        cur = 5;
        for (int k = 0; k < ERR_MAX + 3; k++) begin
            cur = (cur + 5) % 16;
            feed(enc[cur], "sat_jump");
            cur = (cur + 1) % 16;
            feed(enc[cur], "sat_step");
        end
        check("sat.err_cnt", int'(err_cnt), ERR_MAX);

        // Reset mid-lock: next ce is only a first sample
        do_reset("rst_mid");
        feed(enc[cur], "first");
        check("first.locked", int'(locked), 0);
        feed(enc[(cur + 1) % 16], "first");

        // Randomized walk with holds, reversals, jumps, gating, clears and resets
        cur = 0; walk_dir = 1;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      cur = (cur + walk_dir + 16) % 16;
            else if (r < 62) begin walk_dir = -walk_dir; cur = (cur + walk_dir + 16) % 16; end
            else if (r < 72) cur = cur;
            else             cur = $urandom_range(0, 15);
            if ($urandom_range(0, 399) == 0) do_reset("rnd_rst");
            cycle($urandom_range(0, 4) != 0, enc[cur], $urandom_range(0, 60) == 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
